iter_muldiv: RTL and testbench
==============================

Name: iter_muldiv

Overview:
Parametrised iterative multiply/divide unit holding the HI/LO result pair for the MIPS core, executing mult/multu/div/divu alongside the single-cycle ALU. It processes one bit per clock using a start/busy/done handshake. The controller stalls mfhi/mflo while the unit is busy. Width is generic; the core instantiates WIDTH=32.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (>=4)

Ports:
clk      input   1       clock, rising edge
reset    input   1       asynchronous, active-high
start    input   1       request a new operation; sampled only in IDLE
op       input   2       00 multu, 01 mult, 10 divu, 11 div
a        input   WIDTH   multiplicand / dividend (rs)
b        input   WIDTH   multiplier / divisor (rt)
hi_we    input   1       mthi write strobe
lo_we    input   1       mtlo write strobe
wdata    input   WIDTH   mthi/mtlo data
busy     output  1       operation in progress
done     output  1       one-cycle pulse when a new hi/lo is valid
hi       output  WIDTH   HI register
lo       output  WIDTH   LO register

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. Reset forces state=IDLE, hi=0, lo=0, done=0, busy=0, counter=0. Reset mid-operation abandons the operation with no partial result.
- FSM states: IDLE, RUN, FIX. busy = (state != IDLE), combinational from state.
- IDLE with start=1 at edge E0: latch operands and op. For signed ops, take absolute values and record the result signs. Set counter=WIDTH-1 and go to RUN.
- RUN, edges E1..E_WIDTH: one shift-add (multiply) or restoring shift-subtract (divide) step per edge. counter decrements. At counter==0 go to FIX (at edge E_WIDTH).
- FIX, edge E_WIDTH+1: apply sign correction, write hi/lo, set done=1, go to IDLE.
- Latency: done is high during the cycle after edge E_WIDTH+1, i.e. 33 edges after start for WIDTH=32. busy is low in that same cycle.
- done is registered, lasts exactly one cycle, and is cleared on the next edge.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product.
- Divide result: lo = quotient, truncated toward zero; hi = remainder, same sign as the dividend.
- Divide by zero (b==0, either divide op): lo = all ones, hi = a.
  - The operation still takes the full latency.
- Signed overflow (div, a = most negative value, b = -1): lo = a, hi = 0.
- start while busy: ignored; no queueing, and the operation in flight is unaffected.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0: written on the edge, both may be written in the same cycle, done not asserted.
  - Dropped while busy, and dropped in the cycle start is accepted (start has priority).
- hi/lo hold their value throughout RUN/FIX. Only the FIX edge, mthi/mtlo or reset changes them.
- op and operand inputs are don't-care except at the edge where start is accepted.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined: op=01 and op=11 perform signed mult/div as described above.
- Undefined: op[0] is ignored. mult behaves as multu and div as divu, the sign-fix logic is not built, and latency is unchanged.
  - The overflow rule does not apply. The divide-by-zero rule still applies.

Test Plan:
- Reset, then multu a=0xFFFFFFFF b=0xFFFFFFFF -> busy=1 for 33 cycles; done pulse after edge 33; hi=0xFFFFFFFE lo=0x00000001.
- With MDU_SIGNED_EN, mult a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1.
  - Without the macro, same stimulus -> hi=0x00000004 lo=0xFFFFFFF1.
- div a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
  - div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- divu a=100 b=0 -> lo=0xFFFFFFFF hi=0x00000064, done after the same 33 edges.
- During busy, pulse start with new operands and assert hi_we wdata=0x1234 -> both ignored; original result lands. Afterwards in IDLE, lo_we wdata=0xABCD -> lo=0xABCD next edge, no done pulse.
- Start multu, assert reset at cycle 10 -> busy=0, done=0, hi=lo=0 immediately; a new start after reset release completes normally.

Source files
------------

// File: rtl/iter_muldiv_if.sv
// iter_muldiv_if: handshake and HI/LO bus for the iterative multiply/divide
// unit.
//   start/op/a/b   request a new operation (master -> unit)
//   hi_we/lo_we    mthi/mtlo write strobes carrying wdata (master -> unit)
//   busy/done      operation in progress / one-cycle result-valid pulse
//   hi/lo          architectural HI and LO registers (unit -> master)
interface iter_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative one-bit-per-clock multiply/divide unit holding the
// HI/LO pair (multu/mult/divu/div, plus mthi/mtlo writes).
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    iter_muldiv_if.slave: start/op/a/b request, hi_we/lo_we/wdata
//          writes, busy/done status, hi/lo results
// op: 00 multu, 01 mult, 10 divu, 11 div. A result appears WIDTH+1 edges
// after the accepting edge, with done pulsing for one cycle.
// Optional macro MDU_SIGNED_EN builds the signed variants; without it op[0]
// is ignored and no sign-fix logic exists.
module iter_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  iter_muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;     // multiplier->product low half / dividend->quotient
  logic [WIDTH-1:0] opd_q, opd_d;   // multiplicand or divisor magnitude
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
`ifdef MDU_SIGNED_EN
  logic             neg_lo_q, neg_lo_d;  // negate product / quotient
  logic             neg_hi_q, neg_hi_d;  // negate remainder
  logic             a_neg, b_neg;
`endif

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     rs;
  logic               sub_ok;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_res, rem_res;

  always_comb begin
`ifdef MDU_SIGNED_EN
    a_neg = bus.op[0] & bus.a[WIDTH-1];
    b_neg = bus.op[0] & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
`else
    a_mag = bus.a;
    b_mag = bus.b;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    opd_d    = opd_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MDU_SIGNED_EN
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
`endif

    // Shift-add step: {acc,sh} = ({acc,sh} + (sh[0] ? opd<<W : 0)) >> 1
    add_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : '0);

    // Restoring step: shift next dividend bit into the remainder, subtract
    // if it fits. The shifted remainder is W+1 bits but any accepted
    // difference is below the divisor, so W bits of it suffice.
    rs     = {acc_q, sh_q[WIDTH-1]};
    sub_ok = rs[WIDTH] | (rs[WIDTH-1:0] >= opd_q);
    diff   = rs[WIDTH-1:0] - opd_q;

    // A zero divisor needs no special case in the datapath: every trial
    // subtract succeeds, giving all-ones quotient and remainder = dividend.
    prod    = {acc_q, sh_q};
    quo_res = sh_q;
    rem_res = acc_q;
`ifdef MDU_SIGNED_EN
    if (neg_lo_q) begin
      prod    = -prod;
      quo_res = -sh_q;
    end
    if (neg_hi_q) rem_res = -acc_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          cnt_d    = CW'(WIDTH - 1);
          acc_d    = '0;
          is_div_d = bus.op[1];
          if (bus.op[1]) begin
            sh_d  = a_mag;
            opd_d = b_mag;
          end else begin
            sh_d  = b_mag;
            opd_d = a_mag;
          end
`ifdef MDU_SIGNED_EN
          // Quotient keeps the all-ones divide-by-zero pattern unsigned;
          // the remainder follows the dividend, which then restores a.
          neg_lo_d = (a_neg ^ b_neg) & ~(bus.op[1] & ~|bus.b);
          neg_hi_d = bus.op[1] & a_neg;
`endif
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      RUN: begin
        if (is_div_q) begin
          acc_d = sub_ok ? diff : rs[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], sub_ok};
        end else begin
          acc_d = add_sum[WIDTH:1];
          sh_d  = {add_sum[0], sh_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_res;
          lo_d = quo_res;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
`ifdef MDU_SIGNED_EN
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      opd_q    <= opd_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MDU_SIGNED_EN
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: directed and randomized checks of iter_muldiv (WIDTH=32)
// against an arithmetic reference model of HI/LO.
module tb_iter_muldiv;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  iter_muldiv_if #(.WIDTH(W)) bus ();
  iter_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from plain arithmetic on the operands.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b,
                                output logic [W-1:0] ehi, output logic [W-1:0] elo);
    logic   sgn;
    longint sa, sb;
    logic [63:0] p;
`ifdef MDU_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op[1]) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'b0, a} * {32'b0, b};
      ehi = p[63:32];
      elo = p[31:0];
    end else if (b == '0) begin
      elo = '1;
      ehi = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        elo = a;
        ehi = '0;
      end else begin
        elo = 32'(sa / sb);
        ehi = 32'(sa % sb);
      end
    end else begin
      elo = a / b;
      ehi = a % b;
    end
  endfunction

  // Called at a negedge; returns at the negedge after done was seen.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb, input bit mt_with_start);
    logic [W-1:0] ehi, elo;
    int n;
    model(op, a, b, ehi, elo);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    if (mt_with_start) begin
      bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h5555_AAAA;
    end
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
    n = 0;
    while (!bus.done && n < 40) begin
      check("busy_run", 64'(bus.busy), 64'd1);
      check("hi_hold", 64'(bus.hi), 64'(m_hi));
      check("lo_hold", 64'(bus.lo), 64'(m_lo));
      if (disturb && n == 4) begin
        bus.start = 1'b1; bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom;
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
      end else if (disturb && n == 5) begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n), 64'd33);
    check("done_pulse", 64'(bus.done), 64'd1);
    check("busy_at_done", 64'(bus.busy), 64'd0);
    check("hi_result", 64'(bus.hi), 64'(ehi));
    check("lo_result", 64'(bus.lo), 64'(elo));
    m_hi = ehi;
    m_lo = elo;
    @(negedge clk);
    check("done_clear", 64'(bus.done), 64'd0);
  endtask

  task automatic mt_write(input bit wh, input bit wl, input logic [W-1:0] d);
    bus.hi_we = wh; bus.lo_we = wl; bus.wdata = d;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    check("mt_done", 64'(bus.done), 64'd0);
    check("mt_busy", 64'(bus.busy), 64'd0);
    check("mt_hi", 64'(bus.hi), 64'(m_hi));
    check("mt_lo", 64'(bus.lo), 64'(m_lo));
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_max_lo", 64'(bus.lo), 64'h0000_0000_0000_0001);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    run_op(2'b10, 32'd7, 32'd9, 1'b0, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    // start and mthi while busy are ignored
    run_op(2'b00, 32'd6, 32'd7, 1'b1, 1'b0);
    mt_write(1'b0, 1'b1, 32'h0000_ABCD);
    mt_write(1'b1, 1'b1, 32'hDEAD_BEEF);
    // mthi/mtlo dropped in the cycle start is accepted
    run_op(2'b10, 32'd1000, 32'd7, 1'b0, 1'b1);

    // Reset mid-operation
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_hi", 64'(bus.hi), 64'd0);
    check("mid_rst_lo", 64'(bus.lo), 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);

    // Randomized operations with boundary-biased divisors
    for (int unsigned i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(rop, ra, rb, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
